// File: rtl/key_pkg.sv
// key_pkg: channel FSM state encoding and 1 ms tick divider helper
package key_pkg;

    typedef enum logic [2:0] {REL, PDB, HELD, LONG, RDB} key_fsm_e;

    function automatic int tick_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: raw key pins in, debounced levels and event pulses out
interface key_debounce_if #(parameter int N_KEYS = 4);

    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;

    modport master (output key_in, input key_state, key_press, key_release, key_long);
    modport slave (input key_in, output key_state, key_press, key_release, key_long);

endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel (synchronizer, debounce/long-press FSM, registered pulses)
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_MS        = 1000,
    parameter bit KEY_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pin,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int CW = $clog2(LONG_MS);
    localparam logic [CW-1:0] DEB_END = CW'(DEBOUNCE_MS - 1);
    localparam logic [CW-1:0] LONG_END = CW'(LONG_MS - 1);

    logic [1:0] sync;
    logic p;
    key_fsm_e state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic from_long, from_long_n;
    logic level_n, press_n, release_n, long_n;

    assign p = sync[1] ^ KEY_ACTIVE_LOW;
    assign cnt_inc = cnt + CW'(cnt != '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync        <= {2{KEY_ACTIVE_LOW}};
            state       <= REL;
            cnt         <= '0;
            from_long   <= 1'b0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            sync        <= {sync[0], pin};
            state       <= state_n;
            cnt         <= cnt_n;
            from_long   <= from_long_n;
            key_state   <= level_n;
            key_press   <= press_n;
            key_release <= release_n;
            key_long    <= long_n;
        end
    end

    // RDB remembers whether it came from LONG so a release bounce cannot re-fire key_long
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        from_long_n = from_long;
        level_n     = key_state;
        press_n     = 1'b0;
        release_n   = 1'b0;
        long_n      = 1'b0;
        case (state)
            REL: if (p) begin
                state_n = PDB;
                cnt_n   = '0;
            end
            PDB: if (!p) state_n = REL;
            else if (tick) begin
                if (cnt == DEB_END) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    press_n = 1'b1;
                    level_n = 1'b1;
                end else cnt_n = cnt_inc;
            end
            HELD: if (!p) begin
                state_n     = RDB;
                cnt_n       = '0;
                from_long_n = 1'b0;
            end else if (tick) begin
                if (cnt == LONG_END) begin
                    state_n = LONG;
                    long_n  = 1'b1;
                end else cnt_n = cnt_inc;
            end
            LONG: if (!p) begin
                state_n     = RDB;
                cnt_n       = '0;
                from_long_n = 1'b1;
            end
            RDB: if (p) begin
                state_n = from_long ? LONG : HELD;
                cnt_n   = '0;
            end else if (tick) begin
                if (cnt == DEB_END) begin
                    state_n   = REL;
                    cnt_n     = '0;
                    release_n = 1'b1;
                    level_n   = 1'b0;
                end else cnt_n = cnt_inc;
            end
            default: begin
                state_n = REL;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_debounce.sv
// key_debounce: N debounced key channels sharing one 1 ms tick prescaler
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS         = 4,
    parameter int CLK_HZ         = 50_000_000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_MS        = 1000,
    parameter bit KEY_ACTIVE_LOW = 1
) (
    input logic clk,
    input logic rst_n,
    key_debounce_if.slave bus
);

    localparam int DIV = tick_div(CLK_HZ);
    localparam int PW = $clog2(DIV);

    if (!(LONG_MS > DEBOUNCE_MS && DEBOUNCE_MS >= 2 && CLK_HZ >= 2000)) begin : g_bad_params
        $error("key_debounce: need LONG_MS > DEBOUNCE_MS >= 2 and CLK_HZ >= 2000");
    end

    logic [PW-1:0] presc;
    logic tick;

    assign tick = presc == PW'(DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc <= '0;
        else presc <= tick ? '0 : presc + PW'(1);
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_MS   (DEBOUNCE_MS),
            .LONG_MS       (LONG_MS),
            .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (tick),
            .pin        (bus.key_in[i]),
            .key_state  (bus.key_state[i]),
            .key_press  (bus.key_press[i]),
            .key_release(bus.key_release[i]),
            .key_long   (bus.key_long[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed + random key stimulus checked against a level/run-length reference model
module tb_key_debounce;

    localparam int N = 4;
    localparam int TDIV = 10;
    localparam int DEB = 4;
    localparam int LONG = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int k = 0;
    int t0, tp, np1, nr1;
    bit tick;

    // Reference model: accepted level per key plus run lengths measured in ticks
    logic [N-1:0] s0 = '1, s1 = '1, p;
    logic [N-1:0] lvl = '0, run = '0, hrun = '0, fired = '0;
    logic [N-1:0] e_state = '0, e_press = '0, e_rel = '0, e_long = '0;
    int r[N], h[N];

    // Event log taken from the DUT outputs
    int d_press[N], d_rel[N], d_long[N], d_tpress[N], d_tlong[N];

    key_debounce_if #(.N_KEYS(N)) bus ();

    key_debounce #(
        .N_KEYS        (N),
        .CLK_HZ        (10000),
        .DEBOUNCE_MS   (DEB),
        .LONG_MS       (LONG),
        .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0;
            s0 = '1;
            s1 = '1;
            lvl = '0;
            run = '0;
            hrun = '0;
            fired = '0;
            e_state = '0;
            e_press = '0;
            e_rel = '0;
            e_long = '0;
            for (int i = 0; i < N; i++) begin
                r[i] = 0;
                h[i] = 0;
            end
        end else begin
            cyc++;
            tick = (k % TDIV) == TDIV - 1;
            k++;
            p = ~s1;
            e_press = '0;
            e_rel = '0;
            e_long = '0;
            for (int i = 0; i < N; i++) begin
                if (lvl[i]) begin
                    if (p[i]) begin
                        if (hrun[i] && tick) h[i]++;
                        if (h[i] == LONG && !fired[i]) begin
                            e_long[i] = 1'b1;
                            fired[i] = 1'b1;
                        end
                    end else h[i] = 0;
                end
                hrun[i] = p[i];
                if (p[i] != lvl[i]) begin
                    if (run[i] && tick) r[i]++;
                    if (r[i] == DEB) begin
                        r[i] = 0;
                        lvl[i] = p[i];
                        if (p[i]) begin
                            e_press[i] = 1'b1;
                            h[i] = 0;
                            fired[i] = 1'b0;
                        end else e_rel[i] = 1'b1;
                    end
                end else r[i] = 0;
                run[i] = p[i] != lvl[i];
            end
            e_state = lvl;
            s1 = s0;
            s0 = bus.key_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("key_state", bus.key_state, e_state);
            chk("key_press", bus.key_press, e_press);
            chk("key_release", bus.key_release, e_rel);
            chk("key_long", bus.key_long, e_long);
            for (int i = 0; i < N; i++) begin
                if (bus.key_press[i] === 1'b1) begin
                    d_press[i]++;
                    d_tpress[i] = cyc;
                end
                if (bus.key_release[i] === 1'b1) d_rel[i]++;
                if (bus.key_long[i] === 1'b1) begin
                    d_long[i]++;
                    d_tlong[i] = cyc;
                end
            end
        end
    endtask

    initial begin
        bus.key_in = '1;
        step(3);
        rst_n = 1'b1;

        step(500);
        chk("idle_state", bus.key_state, 0);
        chk("idle_events", d_press[0] + d_press[1] + d_press[2] + d_press[3] + d_long[0] + d_long[1] + d_long[2] + d_long[3], 0);

        bus.key_in[0] = 1'b0;
        t0 = cyc;
        step(60);
        chk("press0_count", d_press[0], 1);
        chk("press0_latency", (d_tpress[0] - t0 - 1) inside {[30:42]}, 1);
        chk("state0_held", bus.key_state[0], 1);

        for (int j = 0; j < 15; j++) begin
            bus.key_in[1] = ~bus.key_in[1];
            step(7);
        end
        chk("bounce1_no_press", d_press[1], 0);
        bus.key_in[1] = 1'b0;
        step(60);
        chk("bounce1_press", d_press[1], 1);

        bus.key_in[2] = 1'b0;
        step(50);
        chk("press2_count", d_press[2], 1);
        tp = d_tpress[2];
        step(250);
        chk("long2_count", d_long[2], 1);
        chk("long2_delay", d_tlong[2] - tp, 200);
        bus.key_in[2] = 1'b1;
        step(60);
        chk("rel2_count", d_rel[2], 1);
        chk("long2_once", d_long[2], 1);

        bus.key_in[0] = 1'b1;
        step(60);
        chk("rel0_count", d_rel[0], 1);
        bus.key_in[0] = 1'b0;
        bus.key_in[3] = 1'b0;
        step(60);
        chk("press0_again", d_press[0], 2);
        chk("press3_count", d_press[3], 1);
        chk("press03_same_cycle", d_tpress[0] - d_tpress[3], 0);

        bus.key_in = '1;
        step(60);
        np1 = d_press[1];
        nr1 = d_rel[1];
        bus.key_in[1] = 1'b0;
        step(15);
        rst_n = 1'b0;
        step(5);
        chk("reset_state", bus.key_state, 0);
        rst_n = 1'b1;
        t0 = cyc;
        step(60);
        chk("reset_fresh_press1", d_press[1], np1 + 1);
        chk("reset_no_release1", d_rel[1], nr1);
        chk("reset_press1_latency", (d_tpress[1] - t0 - 1) inside {[30:42]}, 1);

        bus.key_in = '1;
        step(80);
        for (int j = 0; j < 25; j++) begin
            bus.key_in = N'($urandom);
            step($urandom_range(1, 50));
        end
        bus.key_in = '1;
        step(80);
        chk("random_all_released", bus.key_state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
